lru_tracker: RTL and testbench

LRU_TRACKER -- requirements
Module: lru_tracker

---
 rtl/lru_tracker_if.sv | 32 +++
 rtl/lru_tracker.sv | 144 ++++++++++++++
 tb/tb_lru_tracker.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/lru_tracker_if.sv
// Access/victim-query bus of the LRU age tracker.
// Widths follow the tracker's geometry, so the instance must use the tracker's parameters.
interface lru_tracker_if #(
    parameter int NUM_SETS = 128,
    parameter int WAYS     = 4
);
    localparam int SET_W = $clog2(NUM_SETS);
    localparam int WAY_W = $clog2(WAYS);

    logic             acc_valid;
    logic             acc_ready;
    logic             acc_op;
    logic [SET_W-1:0] acc_set;
    logic [WAY_W-1:0] acc_way;
    logic [WAY_W-1:0] old_age;
    logic             upd_valid;
    logic             acc_err;
    logic             vq_valid;
    logic [SET_W-1:0] vq_set;
    logic [WAY_W-1:0] victim_way;
    logic             victim_valid;

    modport master (
        output acc_valid, acc_op, acc_set, acc_way, vq_valid, vq_set,
        input  acc_ready, old_age, upd_valid, acc_err, victim_way, victim_valid
    );

    modport slave (
        input  acc_valid, acc_op, acc_set, acc_way, vq_valid, vq_set,
        output acc_ready, old_age, upd_valid, acc_err, victim_way, victim_valid
    );
endinterface

// File: rtl/lru_tracker.sv
// Per-set true-LRU tracker: each set holds a permutation of ages (WAYS-1 = MRU, 0 = LRU).
// Ages are swept to identity after reset, then updated by touch/demote and read by victim queries.
module lru_tracker #(
    parameter int NUM_SETS = 128,
    parameter int WAYS     = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    lru_tracker_if.slave  bus
);
    localparam int SET_W = $clog2(NUM_SETS);
    localparam int WAY_W = $clog2(WAYS);
    localparam logic [WAY_W-1:0] AGE_MRU  = WAY_W'(WAYS - 1);
    localparam logic [WAY_W-1:0] AGE_ONE  = WAY_W'(1);
    localparam logic [SET_W-1:0] LAST_SET = SET_W'(NUM_SETS - 1);
    localparam logic [SET_W-1:0] SET_ONE  = SET_W'(1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t           state_q, state_d;
    logic [SET_W-1:0] sweep_q, sweep_d;
    logic [WAY_W-1:0] old_age_q, old_age_d;
    logic [WAY_W-1:0] victim_way_q, victim_way_d;
    logic             upd_valid_q, upd_valid_d;
    logic             acc_err_q, acc_err_d;
    logic             victim_valid_q, victim_valid_d;

    logic [WAY_W-1:0] age_q     [NUM_SETS][WAYS];
    logic [WAY_W-1:0] cur_row   [WAYS];
    logic [WAY_W-1:0] upd_row_d [WAYS];
    logic [WAY_W-1:0] vq_row    [WAYS];

    logic             run;
    logic             acc_in_range;
    logic             vq_in_range;
    logic             acc_fire;
    logic [SET_W-1:0] acc_set_idx;
    logic [WAY_W-1:0] acc_way_idx;
    logic [SET_W-1:0] vq_set_idx;
    logic [WAY_W-1:0] cur_age;
    logic [WAY_W-1:0] victim_found;

    assign run          = (state_q == ST_RUN);
    assign acc_in_range = (32'(bus.acc_set) < 32'(NUM_SETS)) && (32'(bus.acc_way) < 32'(WAYS));
    assign vq_in_range  = (32'(bus.vq_set) < 32'(NUM_SETS));
    assign acc_fire     = run && bus.acc_valid && acc_in_range;

    // Clamp indices so out-of-range requests never address beyond the age array.
    assign acc_set_idx  = acc_in_range ? bus.acc_set : '0;
    assign acc_way_idx  = acc_in_range ? bus.acc_way : '0;
    assign vq_set_idx   = vq_in_range  ? bus.vq_set  : '0;
    assign cur_age      = cur_row[acc_way_idx];

    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
        assign cur_row[gi] = age_q[acc_set_idx][gi];

        assign upd_row_d[gi] =
            (WAY_W'(gi) == acc_way_idx)             ? (bus.acc_op ? '0 : AGE_MRU) :
            (!bus.acc_op && cur_row[gi] > cur_age)  ? cur_row[gi] - AGE_ONE :
            ( bus.acc_op && cur_row[gi] < cur_age)  ? cur_row[gi] + AGE_ONE :
                                                      cur_row[gi];

        // A query hitting the set being updated this cycle sees the post-update ages.
        assign vq_row[gi] = (acc_fire && vq_set_idx == acc_set_idx) ? upd_row_d[gi]
                                                                    : age_q[vq_set_idx][gi];
    end

    always_comb begin
        victim_found = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (vq_row[i] == '0) victim_found = WAY_W'(i);
        end
    end

    always_comb begin
        state_d        = state_q;
        sweep_d        = sweep_q;
        old_age_d      = old_age_q;
        victim_way_d   = victim_way_q;
        upd_valid_d    = 1'b0;
        acc_err_d      = 1'b0;
        victim_valid_d = 1'b0;
        case (state_q)
            ST_INIT: begin
                sweep_d = sweep_q + SET_ONE;
                if (sweep_q == LAST_SET) begin
                    state_d = ST_RUN;
                    sweep_d = '0;
                end
            end
            ST_RUN: begin
                if (bus.acc_valid) begin
                    if (acc_in_range) begin
                        upd_valid_d = 1'b1;
                        old_age_d   = cur_age;
                    end else begin
                        acc_err_d   = 1'b1;
                    end
                end
                if (bus.vq_valid) begin
                    victim_valid_d = 1'b1;
                    victim_way_d   = vq_in_range ? victim_found : '0;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_INIT;
            sweep_q        <= '0;
            old_age_q      <= '0;
            victim_way_q   <= '0;
            upd_valid_q    <= 1'b0;
            acc_err_q      <= 1'b0;
            victim_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            sweep_q        <= sweep_d;
            old_age_q      <= old_age_d;
            victim_way_q   <= victim_way_d;
            upd_valid_q    <= upd_valid_d;
            acc_err_q      <= acc_err_d;
            victim_valid_q <= victim_valid_d;
        end
    end

    // Age storage is deliberately reset-free; the INIT sweep gives it a defined value.
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            for (int i = 0; i < WAYS; i++) age_q[sweep_q][i] <= WAY_W'(i);
        end else if (acc_fire) begin
            for (int i = 0; i < WAYS; i++) age_q[acc_set_idx][i] <= upd_row_d[i];
        end
    end

    assign bus.acc_ready    = run;
    assign bus.old_age      = old_age_q;
    assign bus.upd_valid    = upd_valid_q;
    assign bus.acc_err      = acc_err_q;
    assign bus.victim_way   = victim_way_q;
    assign bus.victim_valid = victim_valid_q;
endmodule

// File: tb/tb_lru_tracker.sv
// Bench for lru_tracker: a default 128x4 instance and a 5x3 instance, checked against
// a recency-list model (list position = age, head = LRU, tail = MRU).
module tb_lru_tracker;
    localparam int NA = 128;
    localparam int WA = 4;
    localparam int NB = 5;
    localparam int WB = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lru_tracker_if #(.NUM_SETS(NA), .WAYS(WA)) ifa ();
    lru_tracker_if #(.NUM_SETS(NB), .WAYS(WB)) ifb ();

    lru_tracker #(.NUM_SETS(NA), .WAYS(WA)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    lru_tracker #(.NUM_SETS(NB), .WAYS(WB)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    int n_checks = 0;
    int n_pass   = 0;
    int last_old [2];

    int ord_a [NA][$];
    int ord_b [NB][$];

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic void model_reset();
        for (int s = 0; s < NA; s++) begin
            ord_a[s].delete();
            for (int w = 0; w < WA; w++) ord_a[s].push_back(w);
        end
        for (int s = 0; s < NB; s++) begin
            ord_b[s].delete();
            for (int w = 0; w < WB; w++) ord_b[s].push_back(w);
        end
        last_old[0] = 0;
        last_old[1] = 0;
    endfunction

    function automatic int age_of(input int sel, input int s, input int w);
        if (sel == 0) begin
            for (int i = 0; i < ord_a[s].size(); i++) if (ord_a[s][i] == w) return i;
        end else begin
            for (int i = 0; i < ord_b[s].size(); i++) if (ord_b[s][i] == w) return i;
        end
        return -1;
    endfunction

    // Touch moves the way to the MRU end of the list, demote to the LRU end.
    function automatic void model_apply(input int sel, input int s, input int w, input bit op);
        int pos = age_of(sel, s, w);
        if (sel == 0) begin
            ord_a[s].delete(pos);
            if (op) ord_a[s].push_front(w); else ord_a[s].push_back(w);
        end else begin
            ord_b[s].delete(pos);
            if (op) ord_b[s].push_front(w); else ord_b[s].push_back(w);
        end
    endfunction

    function automatic int victim_of(input int sel, input int s);
        return (sel == 0) ? ord_a[s][0] : ord_b[s][0];
    endfunction

    task automatic clear_inputs();
        ifa.acc_valid = 1'b0; ifa.acc_op = 1'b0; ifa.acc_set = '0; ifa.acc_way = '0;
        ifa.vq_valid  = 1'b0; ifa.vq_set = '0;
        ifb.acc_valid = 1'b0; ifb.acc_op = 1'b0; ifb.acc_set = '0; ifb.acc_way = '0;
        ifb.vq_valid  = 1'b0; ifb.vq_set = '0;
    endtask

    // One transaction: drive, take one rising edge, check the registered response.
    task automatic step(input int sel, input bit av, input bit op, input int s, input int w,
                        input bit qv, input int qs);
        int ns = (sel == 0) ? NA : NB;
        int nw = (sel == 0) ? WA : WB;
        bit ok = av && (s < ns) && (w < nw);
        int exp_old = last_old[sel];
        int exp_vic = 0;
        int o_upd, o_err, o_old, o_vv, o_vw;
        string p = (sel == 0) ? "A" : "B";
        if (ok) begin
            exp_old = age_of(sel, s, w);
            model_apply(sel, s, w, op);
        end
        if (qv && qs < ns) exp_vic = victim_of(sel, qs);
        if (sel == 0) begin
            ifa.acc_valid = av; ifa.acc_op = op; ifa.acc_set = 7'(s); ifa.acc_way = 2'(w);
            ifa.vq_valid  = qv; ifa.vq_set = 7'(qs);
        end else begin
            ifb.acc_valid = av; ifb.acc_op = op; ifb.acc_set = 3'(s); ifb.acc_way = 2'(w);
            ifb.vq_valid  = qv; ifb.vq_set = 3'(qs);
        end
        @(posedge clk);
        #1;
        if (sel == 0) begin
            o_upd = ifa.upd_valid; o_err = ifa.acc_err; o_old = ifa.old_age;
            o_vv  = ifa.victim_valid; o_vw = ifa.victim_way;
        end else begin
            o_upd = ifb.upd_valid; o_err = ifb.acc_err; o_old = ifb.old_age;
            o_vv  = ifb.victim_valid; o_vw = ifb.victim_way;
        end
        clear_inputs();
        check({p, ".upd_valid"}, o_upd, int'(ok));
        check({p, ".acc_err"}, o_err, int'(av && !ok));
        check({p, ".old_age"}, o_old, exp_old);
        check({p, ".victim_valid"}, o_vv, int'(qv));
        if (qv) check({p, ".victim_way"}, o_vw, exp_vic);
        last_old[sel] = exp_old;
        $display("%s av=%0d op=%0d set=%0d way=%0d qv=%0d qset=%0d | upd=%0d err=%0d old=%0d vv=%0d vw=%0d",
                 p, av, op, s, w, qv, qs, o_upd, o_err, o_old, o_vv, o_vw);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".ready"}, int'(ifa.acc_ready), 0);
        check({tag, ".upd_valid"}, int'(ifa.upd_valid), 0);
        check({tag, ".acc_err"}, int'(ifa.acc_err), 0);
        check({tag, ".victim_valid"}, int'(ifa.victim_valid), 0);
        check({tag, ".old_age"}, int'(ifa.old_age), 0);
        check({tag, ".victim_way"}, int'(ifa.victim_way), 0);
        check({tag, ".B_ready"}, int'(ifb.acc_ready), 0);
    endtask

    // Release reset and time the sweep; A is offered traffic throughout to prove it is ignored.
    task automatic release_and_sweep();
        int na_rdy = -1;
        int nb_rdy = -1;
        bit stray = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ifa.acc_valid = 1'b1; ifa.acc_op = 1'b0; ifa.acc_set = 7'd0; ifa.acc_way = 2'd1;
        ifa.vq_valid  = 1'b1; ifa.vq_set = 7'd0;
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk);
            #1;
            if (ifa.upd_valid || ifa.acc_err || ifa.victim_valid) stray = 1'b1;
            if (nb_rdy < 0 && ifb.acc_ready) nb_rdy = n;
            if (ifa.acc_ready) begin
                na_rdy = n;
                break;
            end
        end
        clear_inputs();
        check("A.init_cycles", na_rdy, NA);
        check("B.init_cycles", nb_rdy, NB);
        check("A.quiet_in_init", int'(stray), 0);
        model_reset();
        $display("sweep done: A ready after %0d cycles, B ready after %0d cycles", na_rdy, nb_rdy);
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("por");
        release_and_sweep();

        step(0, 1'b0, 1'b0, 0, 0, 1'b1, 5);
        step(0, 1'b1, 1'b0, 3, 0, 1'b0, 0);
        step(0, 1'b0, 1'b0, 0, 0, 1'b1, 3);
        step(0, 1'b1, 1'b1, 3, 0, 1'b0, 0);
        step(0, 1'b0, 1'b0, 0, 0, 1'b1, 3);
        step(0, 1'b1, 1'b0, 7, 0, 1'b1, 7);
        step(0, 1'b1, 1'b0, 7, 0, 1'b0, 0);
        step(0, 1'b1, 1'b1, 9, 0, 1'b0, 0);

        step(1, 1'b1, 1'b0, 1, 2, 1'b0, 0);
        step(1, 1'b1, 1'b0, 0, 3, 1'b0, 0);
        step(1, 1'b1, 1'b1, 6, 0, 1'b0, 0);
        step(1, 1'b0, 1'b0, 0, 0, 1'b1, 6);
        step(1, 1'b0, 1'b0, 0, 0, 1'b1, 1);

        for (int i = 0; i < 300; i++) begin
            int s = $urandom_range(0, 15);
            step(0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), s,
                 $urandom_range(0, WA - 1), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 1) != 0) ? s : $urandom_range(0, 15));
        end
        for (int i = 0; i < 300; i++) begin
            int s = $urandom_range(0, 6);
            step(1, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), s,
                 $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 1) != 0) ? s : $urandom_range(0, 7));
        end
        for (int s = 0; s < NB; s++) begin
            for (int w = 0; w < WB; w++) step(1, 1'b1, 1'b0, s, w, 1'b1, s);
        end

        step(0, 1'b1, 1'b0, 2, 0, 1'b0, 0);
        step(0, 1'b1, 1'b0, 2, 3, 1'b1, 2);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun");
        release_and_sweep();
        step(0, 1'b0, 1'b0, 0, 0, 1'b1, 2);
        step(0, 1'b1, 1'b0, 2, 3, 1'b0, 0);
        step(0, 1'b1, 1'b0, 2, 1, 1'b0, 0);
        step(0, 1'b1, 1'b0, 2, 0, 1'b1, 2);
        step(0, 1'b0, 1'b0, 0, 0, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
